// File: rtl/mem_access_unit.sv
// Single-port memory access unit: accepts one load/store request at a time,
// checks alignment and range, drives a registered memory port and returns an extended response.
module mem_access_unit #(
  parameter int         ADDR_BITS     = 13,
  parameter int         READ_LATENCY  = 2,
  parameter logic [1:0] MEM_DISABLE   = 2'b00,
  parameter logic [1:0] MEM_READ_SEXT = 2'b01,
  parameter logic [1:0] MEM_READ_ZEXT = 2'b10,
  parameter logic [1:0] MEM_WRITE     = 2'b11,
  parameter logic [1:0] BYTE          = 2'b00,
  parameter logic [1:0] HALFWORD      = 2'b01,
  parameter logic [1:0] WORD          = 2'b10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [31:0]          req_addr,
  input  logic [1:0]           req_op,
  input  logic [1:0]           req_size,
  input  logic [31:0]          req_wdata,
  output logic                 rsp_valid,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_fault,
  output logic                 mem_en,
  output logic [3:0]           mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, READ_WAIT, RESP} state_t;

  localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);

  state_t                r_state;
  state_t                w_next;
  logic [1:0]            r_cnt;
  logic [1:0]            r_op;
  logic [1:0]            r_size;
  logic [1:0]            r_lane;
  logic                  r_write;
  logic                  r_mem_en;
  logic [3:0]            r_mem_we;
  logic [ADDR_BITS-1:0]  r_mem_addr;
  logic [31:0]           r_mem_wdata;
  logic                  r_rsp_valid;
  logic [31:0]           r_rsp_rdata;
  logic                  r_rsp_fault;

  logic                  w_open;
  logic                  w_accept;
  logic                  w_misalign;
  logic                  w_range;
  logic                  w_fault;
  logic                  w_go;

  function automatic logic [3:0] f_byte_en(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      BYTE:     return 4'b0001 << lane;
      HALFWORD: return lane[1] ? 4'b1100 : 4'b0011;
      WORD:     return 4'b1111;
      default:  return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] f_replicate(input logic [1:0] size, input logic [31:0] d);
    case (size)
      BYTE:     return {4{d[7:0]}};
      HALFWORD: return {2{d[15:0]}};
      default:  return d;
    endcase
  endfunction

  function automatic logic [31:0] f_extract(input logic [31:0] d, input logic [1:0] op,
                                            input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] shifted;
    logic [15:0] half;
    logic        sx;
    shifted = d >> {lane, 3'b000};
    half    = lane[1] ? d[31:16] : d[15:0];
    sx      = (op == MEM_READ_SEXT);
    case (size)
      BYTE:     return {{24{sx & shifted[7]}}, shifted[7:0]};
      HALFWORD: return {{16{sx & half[15]}}, half};
      default:  return d;
    endcase
  endfunction

  assign w_open     = (r_state == IDLE) || (r_state == RESP);
  assign req_ready  = w_open;
  assign w_accept   = req_valid & w_open;
  assign w_misalign = (req_size == 2'b11) ||
                      ((req_size == HALFWORD) && req_addr[0]) ||
                      ((req_size == WORD) && (req_addr[1:0] != 2'b00));
  assign w_range    = |req_addr[31:ADDR_BITS+2];
  assign w_fault    = (req_op != MEM_DISABLE) && (w_misalign || w_range);
  assign w_go       = w_accept && (req_op != MEM_DISABLE) && !w_fault;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, RESP: begin
        if (w_accept) w_next = w_go ? ISSUE : RESP;
        else          w_next = IDLE;
      end
      ISSUE:     w_next = r_write ? RESP : READ_WAIT;
      READ_WAIT: if (r_cnt == 2'd0) w_next = RESP;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= 2'd0;
      r_op        <= 2'b00;
      r_size      <= 2'b00;
      r_lane      <= 2'b00;
      r_write     <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 4'b0000;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'h0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_fault <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 4'b0000;
      r_rsp_valid <= (w_next == RESP);

      if (w_accept) begin
        r_op    <= req_op;
        r_size  <= req_size;
        r_lane  <= req_addr[1:0];
        r_write <= (req_op == MEM_WRITE);
      end

      // Port signals change only on entry to ISSUE; address and data hold elsewhere.
      if (w_go) begin
        r_mem_en    <= 1'b1;
        r_mem_we    <= (req_op == MEM_WRITE) ? f_byte_en(req_size, req_addr[1:0]) : 4'b0000;
        r_mem_addr  <= req_addr[ADDR_BITS+1:2];
        r_mem_wdata <= f_replicate(req_size, req_wdata);
      end

      if ((r_state == ISSUE) && !r_write)
        r_cnt <= CNT_INIT;
      else if ((r_state == READ_WAIT) && (r_cnt != 2'd0))
        r_cnt <= r_cnt - 2'd1;

      if (w_accept && !w_go) begin
        r_rsp_rdata <= 32'h0;
        r_rsp_fault <= w_fault;
      end else if ((r_state == ISSUE) && r_write) begin
        r_rsp_rdata <= 32'h0;
        r_rsp_fault <= 1'b0;
      end else if ((r_state == READ_WAIT) && (r_cnt == 2'd0)) begin
        r_rsp_rdata <= f_extract(mem_rdata, r_op, r_size, r_lane);
        r_rsp_fault <= 1'b0;
      end
    end
  end

  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_fault = r_rsp_fault;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a byte-array reference model predicts each response,
// a monitor process compares whatever the unit returns; two extra instances cover latencies 1 and 4.
`timescale 1ns/1ps
module tb_mem_access_unit;
  localparam int AB = 13;
  localparam int RL = 2;
  localparam logic [1:0] DIS = 2'b00, SEXT = 2'b01, ZEXT = 2'b10, WR = 2'b11;
  localparam logic [1:0] SZB = 2'b00, SZH = 2'b01, SZW = 2'b10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // main instance
  logic          req_valid, req_ready;
  logic [31:0]   req_addr, req_wdata;
  logic [1:0]    req_op, req_size;
  logic          rsp_valid, rsp_fault;
  logic [31:0]   rsp_rdata;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AB-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  mem_access_unit #(.ADDR_BITS(AB), .READ_LATENCY(RL)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_op(req_op), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata));

  // latency-1 and latency-4 instances share one request bus
  logic          aux_valid;
  logic [31:0]   aux_addr, aux_wdata;
  logic [1:0]    aux_op, aux_size;
  logic          d1_req_ready, d1_rsp_valid, d1_rsp_fault, d1_mem_en;
  logic [31:0]   d1_rsp_rdata, d1_mem_wdata, d1_mem_rdata;
  logic [3:0]    d1_mem_we;
  logic [AB-1:0] d1_mem_addr;
  logic          d4_req_ready, d4_rsp_valid, d4_rsp_fault, d4_mem_en;
  logic [31:0]   d4_rsp_rdata, d4_mem_wdata, d4_mem_rdata;
  logic [3:0]    d4_mem_we;
  logic [AB-1:0] d4_mem_addr;

  mem_access_unit #(.ADDR_BITS(AB), .READ_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(aux_valid), .req_ready(d1_req_ready),
    .req_addr(aux_addr), .req_op(aux_op), .req_size(aux_size), .req_wdata(aux_wdata),
    .rsp_valid(d1_rsp_valid), .rsp_rdata(d1_rsp_rdata), .rsp_fault(d1_rsp_fault),
    .mem_en(d1_mem_en), .mem_we(d1_mem_we), .mem_addr(d1_mem_addr), .mem_wdata(d1_mem_wdata),
    .mem_rdata(d1_mem_rdata));

  mem_access_unit #(.ADDR_BITS(AB), .READ_LATENCY(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(aux_valid), .req_ready(d4_req_ready),
    .req_addr(aux_addr), .req_op(aux_op), .req_size(aux_size), .req_wdata(aux_wdata),
    .rsp_valid(d4_rsp_valid), .rsp_rdata(d4_rsp_rdata), .rsp_fault(d4_rsp_fault),
    .mem_en(d4_mem_en), .mem_we(d4_mem_we), .mem_addr(d4_mem_addr), .mem_wdata(d4_mem_wdata),
    .mem_rdata(d4_mem_rdata));

  function automatic logic [31:0] init_word(input int w);
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] aux_word(input logic [AB-1:0] w);
    return (w == 1) ? 32'h80F0_1234 : {19'h0, w};
  endfunction

  // memory models with READ_LATENCY-deep read pipelines
  logic [31:0] mem [0:(1<<AB)-1];
  logic        mem_inited = 1'b0;
  logic [31:0] rpipe [0:RL-1];
  logic [31:0] p1;
  logic [31:0] p4 [0:3];

  always @(posedge clk) begin
    if (!rst_n && !mem_inited) begin
      for (int w = 0; w < (1<<AB); w++) mem[w] <= init_word(w);
      mem_inited <= 1'b1;
    end else if (mem_en && mem_we != 4'b0000) begin
      mem[mem_addr] <= merge(mem[mem_addr], mem_wdata, mem_we);
    end
    rpipe[0] <= mem_en ? mem[mem_addr] : 32'hDEAD_BEEF;
    for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
    p1    <= d1_mem_en ? aux_word(d1_mem_addr) : 32'hDEAD_BEEF;
    p4[0] <= d4_mem_en ? aux_word(d4_mem_addr) : 32'hDEAD_BEEF;
    for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
  end
  assign mem_rdata    = rpipe[RL-1];
  assign d1_mem_rdata = p1;
  assign d4_mem_rdata = p4[3];

  // reference model state and scoreboard
  logic [7:0] rb [0:(1<<(AB+2))-1];
  typedef struct {logic [31:0] rdata; logic fault; int acc; int lat;} exp_t;
  exp_t sb[$];
  int rsp_cycs[$];
  int checks = 0, errors = 0;
  int n_acc_exp = 0, n_acc_seen = 0, viol = 0;
  logic [31:0] last_rdata = 32'h0;
  logic        last_fault = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model(input logic [1:0] op, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, output exp_t e);
    int n;
    logic [31:0] v;
    n = 1 << sz;
    e.rdata = 32'h0;
    e.lat   = 1;
    e.acc   = 0;
    e.fault = (op != DIS) && ((sz == 2'b11) || ((a & (n - 1)) != 0) || ((a >> (AB + 2)) != 0));
    if (op == DIS || e.fault) return;
    n_acc_exp++;
    if (op == WR) begin
      for (int i = 0; i < n; i++) rb[int'(a) + i] = wd[8*i +: 8];
      e.lat = 2;
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = rb[int'(a) + i];
      if (op == SEXT && v[8*n-1]) for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
      e.rdata = v;
      e.lat   = RL + 2;
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int t;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_size = sz; req_addr = a; req_wdata = wd;
    t = 0;
    while (!req_ready && t < 50) begin @(negedge clk); t++; end
    if (!req_ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    model(op, sz, a, wd, e);
    e.acc = cyc;
    sb.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin @(negedge clk); t++; end
    chk("drain_pending", sb.size(), 32'd0);
    @(negedge clk);
  endtask

  task automatic aux_req(input logic [1:0] op, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] exp, input int l1, input int l4);
    int g1, g4;
    logic [31:0] r1, r4;
    g1 = -1; g4 = -1; r1 = 32'h0; r4 = 32'h0;
    @(negedge clk);
    chk("aux_ready", {30'h0, d1_req_ready, d4_req_ready}, 32'd3);
    aux_valid = 1'b1; aux_op = op; aux_size = sz; aux_addr = a;
    @(posedge clk);
    #1 aux_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (d1_rsp_valid && g1 < 0) begin g1 = i; r1 = d1_rsp_rdata; end
      if (d4_rsp_valid && g4 < 0) begin g4 = i; r4 = d4_rsp_rdata; end
    end
    chk("lat1_latency", g1, l1);
    chk("lat1_rdata", r1, exp);
    chk("lat4_latency", g4, l4);
    chk("lat4_rdata", r4, exp);
    chk("aux_fault", {30'h0, d1_rsp_fault, d4_rsp_fault}, 32'd0);
  endtask

  // response monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_rdata = 32'h0;
        last_fault = 1'b0;
      end else begin
        if (mem_en) n_acc_seen++;
        if (!mem_en && mem_we != 4'b0000) viol++;
        if (d1_mem_we != 4'b0000 || d4_mem_we != 4'b0000 || d1_mem_wdata != 0 || d4_mem_wdata != 0) viol++;
        if (rsp_valid) begin
          rsp_cycs.push_back(cyc);
          if (sb.size() == 0) begin
            chk("unexpected_rsp", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_fault", {31'h0, rsp_fault}, {31'h0, e.fault});
            chk("rsp_latency", cyc - e.acc, e.lat);
          end
          last_rdata = rsp_rdata;
          last_fault = rsp_fault;
        end else if (rsp_rdata !== last_rdata || rsp_fault !== last_fault) begin
          viol++;
        end
      end
    end
  end

  initial begin
    logic [1:0]  op, sz;
    logic [31:0] a;
    for (int w = 0; w < (1<<AB); w++)
      for (int i = 0; i < 4; i++) rb[4*w + i] = init_word(w) >> (8*i);
    req_valid = 1'b0; req_op = DIS; req_size = SZB; req_addr = 32'h0; req_wdata = 32'h0;
    aux_valid = 1'b0; aux_op = DIS; aux_size = SZB; aux_addr = 32'h0; aux_wdata = 32'h0;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {26'h0, mem_en, mem_we, rsp_valid, rsp_fault}, 32'd0);
    chk("reset_data", mem_wdata | rsp_rdata | {19'h0, mem_addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {31'h0, req_ready}, 32'd1);

    // store byte and check the port during ISSUE
    issue(WR, SZB, 32'h6, 32'h0000_00A5);
    @(negedge clk);
    chk("sb_mem_en", {31'h0, mem_en}, 32'd1);
    chk("sb_mem_we", {28'h0, mem_we}, 32'h4);
    chk("sb_mem_addr", {19'h0, mem_addr}, 32'd1);
    chk("sb_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
    drain();

    // word 1 = 0x80F01234, then sign/zero-extended sub-word loads
    issue(WR, SZW, 32'h4, 32'h80F0_1234);
    issue(SEXT, SZB, 32'h6, 32'h0);
    issue(ZEXT, SZH, 32'h6, 32'h0);
    drain();

    // misaligned and out-of-range words fault without memory access
    issue(ZEXT, SZW, 32'h2, 32'h0);
    issue(ZEXT, SZW, 32'h0002_0000, 32'h0);
    issue(DIS, 2'b11, 32'hFFFF_FFFF, 32'h0);
    drain();

    // back-to-back reads
    rsp_cycs.delete();
    issue(ZEXT, SZW, 32'h8, 32'h0);
    issue(SEXT, SZH, 32'hA, 32'h0);
    drain();
    if (rsp_cycs.size() >= 2) chk("b2b_spacing", rsp_cycs[1] - rsp_cycs[0], RL + 2);
    else                      chk("b2b_count", rsp_cycs.size(), 32'd2);

    // reset during READ_WAIT abandons the read
    issue(ZEXT, SZW, 32'hC, 32'h0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", {26'h0, mem_en, mem_we, rsp_valid, rsp_fault}, 32'd0);
    chk("midrst_data", mem_wdata | rsp_rdata | {19'h0, mem_addr}, 32'd0);
    sb.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    issue(ZEXT, SZW, 32'h4, 32'h0);
    drain();

    // latency 1 and 4 instances
    aux_req(SEXT, SZB, 32'h6, 32'hFFFF_FFF0, 3, 6);
    aux_req(ZEXT, SZH, 32'h6, 32'h0000_80F0, 3, 6);

    // randomized traffic
    for (int n = 0; n < 250; n++) begin
      op = 2'($urandom_range(0, 3));
      sz = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 127));
      issue(op, sz, a, $urandom);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain();

    chk("mem_access_count", n_acc_seen, n_acc_exp);
    chk("port_and_hold_violations", viol, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter ADDR_BITS, default 13: word-address width of the memory port (byte space = 2^(ADDR_BITS+2)).
REQ-002 Parameter READ_LATENCY, default 2, legal 1..4: cycles from mem_en high to mem_rdata valid.
REQ-003 Parameters MEM_DISABLE=2'b00, MEM_READ_SEXT=2'b01, MEM_READ_ZEXT=2'b10, MEM_WRITE=2'b11 shall encode req_op.
REQ-004 Parameters BYTE=2'b00, HALFWORD=2'b01, WORD=2'b10 shall encode req_size; 2'b11 is illegal.
REQ-005 clk  in  1  sole clock; all state changes on the rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  unit can accept a request this cycle.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_op  in  2  memory operation.
REQ-011 req_size  in  2  access size.
REQ-012 req_wdata  in  32  store data, right-aligned.
REQ-013 rsp_valid  out  1  one-cycle response pulse.
REQ-014 rsp_rdata  out  32  extended load result; 0 for non-loads.
REQ-015 rsp_fault  out  1  request rejected (misaligned, out of range, illegal size); qualified by rsp_valid.
REQ-016 mem_en  out  1  memory port enable (registered).
REQ-017 mem_we  out  4  byte write enables (registered).
REQ-018 mem_addr  out  ADDR_BITS  word address = req_addr[ADDR_BITS+1:2] (registered).
REQ-019 mem_wdata  out  32  lane-replicated store data (registered).
REQ-020 mem_rdata  in  32  memory read data.

Function
REQ-021 FSM states IDLE, ISSUE, READ_WAIT, RESP; req_ready shall be 1 only in IDLE and RESP.
REQ-022 Handshake: a request shall be accepted in the cycle req_valid & req_ready; req_* fields shall be captured into internal registers at that edge.
REQ-023 Fault check at acceptance: HALFWORD with addr[0]=1, WORD with addr[1:0]!=0, size 2'b11, or req_addr[31:ADDR_BITS+2]!=0 shall be a fault; MEM_DISABLE never faults.
REQ-024 Faulted or MEM_DISABLE request: no memory access; next state RESP; rsp_valid=1 next cycle with rsp_fault=fault, rsp_rdata=0.
REQ-025 Legal request -> ISSUE: mem_en=1 for exactly this one cycle; mem_we per REQ-026 for writes, 4'b0000 for reads.
REQ-026 Write enables: BYTE -> 4'b0001<<addr[1:0]; HALFWORD -> 4'b0011 (addr[1]=0) or 4'b1100 (addr[1]=1); WORD -> 4'b1111.
REQ-027 Write data: BYTE -> {4{wdata[7:0]}}; HALFWORD -> {2{wdata[15:0]}}; WORD -> wdata.
REQ-028 Write from ISSUE -> RESP: rsp_valid in the cycle after ISSUE, rsp_fault=0, rsp_rdata=0; total latency accept-to-rsp_valid 2 cycles.
REQ-029 Read from ISSUE -> READ_WAIT; a down-counter loaded with READ_LATENCY-1 shall decrement each cycle; at counter 0 mem_rdata shall be sampled and state -> RESP.
REQ-030 Read extraction: lane selected by captured addr[1:0] (byte) or addr[1] (halfword); MEM_READ_SEXT sign-extends bit 7/15, MEM_READ_ZEXT zero-fills.
REQ-031 Read latency: rsp_valid in cycle ISSUE+READ_LATENCY+1 (accept-to-rsp_valid READ_LATENCY+2 cycles).
REQ-032 RESP lasts one cycle; a request accepted in RESP shall be processed back-to-back (next state per REQ-024/025); else -> IDLE.
REQ-033 mem_en, mem_we shall be 0 in every state except ISSUE; mem_addr/mem_wdata shall hold their last values outside ISSUE.
REQ-034 rsp_rdata/rsp_fault shall hold their values until the next response.

Reset
REQ-035 rst_n low shall asynchronously force state IDLE, counter 0, req_ready=1 after release, and mem_en, mem_we, mem_addr, mem_wdata, rsp_valid, rsp_rdata, rsp_fault all 0.
REQ-036 Reset mid-read shall abandon the access; no rsp_valid shall follow for it after rst_n rises.

Verification
REQ-037 SB to 0x0000_0006, wdata 0x0000_00A5 -> ISSUE: mem_we=4'b0100, mem_addr=1, mem_wdata=0xA5A5A5A5; rsp_valid next cycle.
REQ-038 mem word 1 = 0x80F0_1234, LB SEXT addr 0x6 -> rsp_rdata=0xFFFF_FFF0; LHU addr 0x6 -> 0x0000_80F0; both READ_LATENCY+2 cycles after accept.
REQ-039 LW addr 0x2 -> no mem_en, rsp_valid next cycle, rsp_fault=1, rsp_rdata=0; addr 0x0002_0000 (ADDR_BITS=13) -> same fault.
REQ-040 Two reads back-to-back with req_valid held high -> second accepted in first's RESP cycle, rsp_valid pulses spaced READ_LATENCY+2 cycles apart.
REQ-041 rst_n pulsed low during READ_WAIT -> all outputs 0 immediately, no rsp_valid after release, next request served normally.
REQ-042 Repeat REQ-038 with READ_LATENCY=1 and 4 -> latency 3 and 6 cycles respectively.
